uart_receive_controller: RTL

- Deserializes the UART RX pin into bytes, LSB first, 8N1 framing.
- Samples at OVERSAMPLE x baud, qualified by an RX clock-enable tick from the shared baud generator.
- Presents each received byte with an Empty/Unload_data handshake, plus framing-error and overrun flags.
- Receive-side counterpart of the UART transmit controller, on the same Clock and baud-enable infrastructure.

---
 rtl/uart_receive_controller_pkg.sv | 21 ++
 rtl/uart_rx_synchronizer.sv | 23 ++
 rtl/uart_receive_controller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_receive_controller_pkg.sv
// Shared UART controller types: transmit and receive state encodings plus default frame geometry.
package uart_receive_controller_pkg;

  localparam int unsigned DEFAULT_OVERSAMPLE = 16;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    S_TXC_IDLE,
    S_TXC_START_BIT,
    S_TXC_DATA,
    S_TXC_STOP_BIT
  } TX_Controller_state_type;

  typedef enum logic [1:0] {
    S_RXC_IDLE,
    S_RXC_START_BIT,
    S_RXC_DATA,
    S_RXC_STOP_BIT
  } RX_Controller_state_type;

endpackage

// File: rtl/uart_rx_synchronizer.sv
// Two-flop synchronizer for the asynchronous RX pin; resets to the idle-high line level.
module uart_rx_synchronizer
  import uart_receive_controller_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] sync_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], async_i};
    end
  end

  assign sync_o = sync_q[1];

endmodule

// File: rtl/uart_receive_controller.sv
// 8N1 UART receiver: oversampled start/data/stop bit timing with an Empty/Unload_data
// holding register and framing-error / overrun reporting.
module uart_receive_controller
  import uart_receive_controller_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  RX_clock_enable,
  input  logic                  Enable,
  input  logic                  Unload_data,
  input  logic                  UART_RX_I,
  output logic [DATA_WIDTH-1:0] RX_data,
  output logic                  Empty,
  output logic                  Frame_error,
  output logic                  Overrun
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);

  RX_Controller_state_type state_q, state_d;
  logic [SW-1:0]         sampleCnt_q, sampleCnt_d;
  logic [BW-1:0]         bitCnt_q, bitCnt_d;
  logic [DATA_WIDTH-1:0] shiftBuf_q, shiftBuf_d;
  logic [DATA_WIDTH-1:0] rxData_q, rxData_d;
  logic                  empty_q, empty_d;
  logic                  frameErr_q, frameErr_d;
  logic                  overrun_q, overrun_d;
  logic                  rxSync;
  logic                  stopSample;

  uart_rx_synchronizer u_sync (
    .Clock   (Clock),
    .Reset   (Reset),
    .async_i (UART_RX_I),
    .sync_o  (rxSync)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_RXC_IDLE;
      sampleCnt_q <= '0;
      bitCnt_q    <= '0;
      shiftBuf_q  <= '0;
      rxData_q    <= '0;
      empty_q     <= 1'b1;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sampleCnt_q <= sampleCnt_d;
      bitCnt_q    <= bitCnt_d;
      shiftBuf_q  <= shiftBuf_d;
      rxData_q    <= rxData_d;
      empty_q     <= empty_d;
      frameErr_q  <= frameErr_d;
      overrun_q   <= overrun_d;
    end
  end

  // Bit timing: decisions land mid-bit; the stop sample returns to idle at once so a
  // following start edge inside the second half of the stop bit is still caught.
  always_comb begin
    state_d     = state_q;
    sampleCnt_d = sampleCnt_q;
    bitCnt_d    = bitCnt_q;
    shiftBuf_d  = shiftBuf_q;
    stopSample  = 1'b0;

    if (!Enable) begin
      state_d     = S_RXC_IDLE;
      sampleCnt_d = '0;
      bitCnt_d    = '0;
    end else if (RX_clock_enable) begin
      case (state_q)
        S_RXC_IDLE: begin
          if (!rxSync) begin
            sampleCnt_d = '0;
            state_d     = S_RXC_START_BIT;
          end
        end
        S_RXC_START_BIT: begin
          if (sampleCnt_q == HALF_LAST) begin
            sampleCnt_d = '0;
            bitCnt_d    = '0;
            state_d     = rxSync ? S_RXC_IDLE : S_RXC_DATA;
          end else begin
            sampleCnt_d = sampleCnt_q + 1'b1;
          end
        end
        S_RXC_DATA: begin
          if (sampleCnt_q == BIT_LAST) begin
            sampleCnt_d = '0;
            shiftBuf_d  = {rxSync, shiftBuf_q[DATA_WIDTH-1:1]};
            if (bitCnt_q == DATA_LAST) begin
              bitCnt_d = '0;
              state_d  = S_RXC_STOP_BIT;
            end else begin
              bitCnt_d = bitCnt_q + 1'b1;
            end
          end else begin
            sampleCnt_d = sampleCnt_q + 1'b1;
          end
        end
        S_RXC_STOP_BIT: begin
          if (sampleCnt_q == BIT_LAST) begin
            sampleCnt_d = '0;
            stopSample  = 1'b1;
            state_d     = S_RXC_IDLE;
          end else begin
            sampleCnt_d = sampleCnt_q + 1'b1;
          end
        end
        default: state_d = S_RXC_IDLE;
      endcase
    end
  end

  // A same-cycle unload frees the holding register for the byte arriving on that edge.
  always_comb begin
    rxData_d   = rxData_q;
    empty_d    = empty_q;
    frameErr_d = frameErr_q;
    overrun_d  = overrun_q;

    if (stopSample) begin
      if (empty_q || Unload_data) begin
        rxData_d   = shiftBuf_q;
        empty_d    = 1'b0;
        frameErr_d = ~rxSync;
        overrun_d  = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (Unload_data && !empty_q) begin
      empty_d    = 1'b1;
      frameErr_d = 1'b0;
      overrun_d  = 1'b0;
    end
  end

  assign RX_data     = rxData_q;
  assign Empty       = empty_q;
  assign Frame_error = frameErr_q;
  assign Overrun     = overrun_q;

endmodule
